// File: rtl/fp_dot_acc.sv
// Sequential floating-point dot-product accumulator: one operand pair per 3 cycles, VLEN pairs per result.
// Optional sticky abnormal-operand flag output `abn` is enabled by defining FP_DOT_ACC_ABN_FLAG_EN.
module fp_dot_acc #(
    parameter int NX   = 8,
    parameter int NM   = 23,
    parameter int VLEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NX+NM:0]   a,
    input  logic [NX+NM:0]   b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NX+NM:0]   res
`ifdef FP_DOT_ACC_ABN_FLAG_EN
    ,
    output logic             abn
`endif
);
    localparam int N  = NX + NM + 1;
    localparam int CW = $clog2(VLEN) + 1;
    localparam logic [CW-1:0]        LAST   = CW'(VLEN - 1);
    localparam logic [NX-1:0]        EMAX   = '1;
    localparam logic signed [NX+1:0] BIAS   = (NX+2)'((1 << (NX - 1)) - 1);
    localparam logic signed [NX+1:0] EMAX_S = (NX+2)'((1 << NX) - 1);
    localparam logic signed [NX+1:0] E_ONE  = 1;
    localparam logic signed [NX+1:0] E_ZERO = 0;

    // Handshakes: a pair transfers on a rising edge with in_valid && in_ready;
    // a result transfers on a rising edge with out_valid && out_ready.
    typedef enum logic [1:0] {S_LOAD, S_MUL, S_ACC, S_OUT} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [N-1:0]  a_r, b_r, prod, acc;

    // Truncating multiply; an all-ones exponent operand is passed through, zero exponent gives signed zero.
    function automatic logic [N-1:0] fp_mul(input logic [N-1:0] x, input logic [N-1:0] y);
        logic                s;
        logic [2*NM+1:0]     p;
        logic signed [NX+1:0] e;
        logic [NM-1:0]       m;
        s = x[N-1] ^ y[N-1];
        if (x[N-2:NM] == EMAX) return x;
        if (y[N-2:NM] == EMAX) return y;
        if (x[N-2:NM] == '0 || y[N-2:NM] == '0) return {s, {(N-1){1'b0}}};
        p = {{(NM+1){1'b0}}, 1'b1, x[NM-1:0]} * {{(NM+1){1'b0}}, 1'b1, y[NM-1:0]};
        e = $signed({2'b00, x[N-2:NM]}) + $signed({2'b00, y[N-2:NM]}) - BIAS;
        if (p[2*NM+1]) begin
            e = e + E_ONE;
            m = p[2*NM:NM+1];
        end else begin
            m = p[2*NM-1:NM];
        end
        if (e >= EMAX_S) return {s, EMAX, {NM{1'b0}}};
        if (e <= E_ZERO) return {s, {(N-1){1'b0}}};
        return {s, e[NX-1:0], m};
    endfunction

    // Truncating add: align the smaller magnitude, add/subtract, renormalise.
    function automatic logic [N-1:0] fp_add(input logic [N-1:0] x_in, input logic [N-1:0] y_in);
        logic [N-1:0]         x, y;
        logic [NM+1:0]        mx, my, sum;
        logic [NX-1:0]        d;
        logic signed [NX+1:0] e;
        int                   lz;
        if (x_in[N-2:NM] == EMAX) return x_in;
        if (y_in[N-2:NM] == EMAX) return y_in;
        if (x_in[N-2:NM] == '0) return y_in;
        if (y_in[N-2:NM] == '0) return x_in;
        if (x_in[N-2:0] >= y_in[N-2:0]) begin
            x = x_in;
            y = y_in;
        end else begin
            x = y_in;
            y = x_in;
        end
        d  = x[N-2:NM] - y[N-2:NM];
        mx = {2'b01, x[NM-1:0]};
        my = {2'b01, y[NM-1:0]};
        my = (int'(d) > NM + 1) ? '0 : (my >> d);
        e  = $signed({2'b00, x[N-2:NM]});
        if (x[N-1] == y[N-1]) begin
            sum = mx + my;
            if (sum[NM+1]) begin
                sum = sum >> 1;
                e   = e + E_ONE;
            end
        end else begin
            sum = mx - my;
            if (sum == '0) return '0;
            lz = 0;
            for (int i = 0; i <= NM; i++)
                if (sum[i]) lz = NM - i;
            sum = sum << lz;
            e   = e - (NX+2)'(lz);
        end
        if (e >= EMAX_S) return {x[N-1], EMAX, {NM{1'b0}}};
        if (e <= E_ZERO) return {x[N-1], {(N-1){1'b0}}};
        return {x[N-1], e[NX-1:0], sum[NM-1:0]};
    endfunction

    assign in_ready = (state == S_LOAD);
    assign res      = acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_LOAD;
            count     <= '0;
            a_r       <= '0;
            b_r       <= '0;
            prod      <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        state <= S_MUL;
                    end
                end
                S_MUL: begin
                    prod  <= fp_mul(a_r, b_r);
                    state <= S_ACC;
                end
                S_ACC: begin
                    // First product of a vector loads directly so a -0 product is not lost to 0 + x.
                    acc <= (count == '0) ? prod : fp_add(acc, prod);
                    if (count == LAST) begin
                        count     <= '0;
                        state     <= S_OUT;
                        out_valid <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                        state <= S_LOAD;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        acc       <= '0;
                        out_valid <= 1'b0;
                        state     <= S_LOAD;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

`ifdef FP_DOT_ACC_ABN_FLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            abn <= 1'b0;
        else if (state == S_LOAD && in_valid && (a[N-2:NM] == EMAX || b[N-2:NM] == EMAX))
            abn <= 1'b1;
        else if (state == S_OUT && out_ready)
            abn <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_fp_dot_acc.sv
// Directed bench for fp_dot_acc (VLEN=4, single precision); ABN checks build when FP_DOT_ACC_ABN_FLAG_EN is defined.
module tb_fp_dot_acc;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] res;
    logic        in_ready;
    logic        out_valid;
`ifdef FP_DOT_ACC_ABN_FLAG_EN
    logic        abn;
`endif

    int checks = 0;
    int failures = 0;

    logic [31:0] tab_a [2][4] = '{'{32'h3F800000, 32'h40400000, 32'h3F000000, 32'h3F800000},
                                  '{32'hBF800000, 32'h40400000, 32'h3F800000, 32'h3F800000}};
    logic [31:0] tab_b [2][4] = '{'{32'h40000000, 32'h40800000, 32'h40000000, 32'h3F800000},
                                  '{32'h40000000, 32'h40000000, 32'h3F800000, 32'h3F800000}};

    fp_dot_acc #(.NX(8), .NM(23), .VLEN(4)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .res(res)
`ifdef FP_DOT_ACC_ABN_FLAG_EN
        ,
        .abn(abn)
`endif
    );

    always #5 clk = ~clk;

    // Waits (bounded) for in_ready, presents one pair for exactly one edge, then scrambles A/B.
    task automatic push(input logic [31:0] pa, input logic [31:0] pb);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL push_ready: in_ready=%b required 1", in_ready);
        end
        a = pa;
        b = pb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    // Pushes a table vector and checks result latency and value; leaves the DUT in OUT.
    task automatic run_vector(input int sel, input logic [31:0] exp_res);
        for (int i = 0; i < 4; i++) push(tab_a[sel][i], tab_b[sel][i]);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL lat_mul: out_valid=%b required 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL lat_acc: out_valid=%b required 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL lat_out: out_valid=%b required 1", out_valid);
        end
        checks++;
        if (res !== exp_res) begin
            failures++;
            $display("FAIL res_vec%0d: res=%h required %h", sel, res, exp_res);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL out_in_ready: in_ready=%b required 0", in_ready);
        end
    endtask

    // Completes the OUT handshake and checks the return to LOAD with a cleared accumulator.
    task automatic complete_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL out_done: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        checks++;
        if (res !== 32'h0) begin
            failures++;
            $display("FAIL acc_clear: res=%h required 00000000", res);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || res !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b res=%h required 1 0 00000000",
                     in_ready, out_valid, res);
        end
        rst = 1'b0;
    endtask

    task automatic test_vec_positive();
        run_vector(0, 32'h41800000);
        complete_out();
    endtask

    task automatic test_vec_mixed_sign();
        run_vector(1, 32'h40C00000);
        complete_out();
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        run_vector(0, 32'h41800000);
        held = res;
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            a = $urandom;
            b = $urandom;
            @(negedge clk);
            checks++;
            if (res !== 32'h41800000 || held !== 32'h41800000) begin
                failures++;
                $display("FAIL bp_res_stable: res=%h required 41800000", res);
            end
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold: in_ready=%b out_valid=%b required 0 1", in_ready, out_valid);
            end
        end
        in_valid = 1'b0;
        complete_out();
    endtask

    task automatic test_reset_mid();
        push(32'h41200000, 32'h41200000);
        push(32'h41200000, 32'h41200000);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (res !== 32'h0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: res=%h in_ready=%b out_valid=%b required 00000000 1 0",
                     res, in_ready, out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        run_vector(0, 32'h41800000);
        complete_out();
    endtask

    task automatic test_back_to_back();
        int k = 0;
        int t = 0;
        in_valid = 1'b1;
        a = $urandom;
        b = $urandom;
        @(negedge clk);
        while (!out_valid && t < 40) begin
            if (in_ready) begin
                a = (k < 4) ? tab_a[1][k] : $urandom;
                b = (k < 4) ? tab_b[1][k] : $urandom;
                k++;
            end else begin
                a = $urandom;
                b = $urandom;
            end
            @(negedge clk);
            t++;
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL stream_timeout: out_valid=%b required 1", out_valid);
        end
        checks++;
        if (k != 4) begin
            failures++;
            $display("FAIL stream_captures: load_cycles=%0d required 4", k);
        end
        checks++;
        if (res !== 32'h40C00000) begin
            failures++;
            $display("FAIL stream_res: res=%h required 40c00000", res);
        end
        complete_out();
    endtask

`ifdef FP_DOT_ACC_ABN_FLAG_EN
    task automatic test_abn_flag();
        int t = 0;
        checks++;
        if (abn !== 1'b0) begin
            failures++;
            $display("FAIL abn_idle: abn=%b required 0", abn);
        end
        push(32'h7F800000, 32'h3F800000);
        checks++;
        if (abn !== 1'b1) begin
            failures++;
            $display("FAIL abn_set: abn=%b required 1", abn);
        end
        for (int i = 1; i < 4; i++) push(32'h3F800000, 32'h3F800000);
        while (!out_valid && t < 10) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (out_valid !== 1'b1 || abn !== 1'b1) begin
            failures++;
            $display("FAIL abn_sticky: out_valid=%b abn=%b required 1 1", out_valid, abn);
        end
        complete_out();
        checks++;
        if (abn !== 1'b0) begin
            failures++;
            $display("FAIL abn_clear: abn=%b required 0", abn);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_vec_positive();
        test_vec_mixed_sign();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef FP_DOT_ACC_ABN_FLAG_EN
        test_abn_flag();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time exceeded");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fp_dot_acc.md
FP_DOT_ACC -- requirements
Module: fp_dot_acc

Interface
REQ-001 SHALL have parameter NX, default 8, exponent width of the operand and result format.
REQ-002 SHALL have parameter NM, default 23, mantissa width; N = NX+NM+1.
REQ-003 SHALL have parameter VLEN, default 4, number of operand pairs per dot product (VLEN >= 1).
REQ-004 CLK  input  1  sole clock, rising-edge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 IN_VALID  input  1  operand pair A/B valid.
REQ-007 IN_READY  output  1  block accepts a pair this cycle.
REQ-008 A  input  N  IEEE754-layout operand {sign, exp, mant}.
REQ-009 B  input  N  IEEE754-layout operand.
REQ-010 OUT_VALID  output  1  RES holds a completed dot product.
REQ-011 OUT_READY  input  1  consumer takes RES.
REQ-012 RES  output  N  accumulated sum of products.

Function
REQ-013 SHALL implement FSM states LOAD, MUL, ACC, OUT; IN_READY = (state==LOAD), combinational from state only.
REQ-014 LOAD: on IN_VALID&&IN_READY, register A,B and go to MUL; otherwise hold.
REQ-015 MUL: register product using the codebase fpu mul semantics (truncating, abnormal/zero operand passthrough); go to ACC.
REQ-016 ACC: if count==0, load the accumulator with the product directly (no add with zero); otherwise acc = fpu add(acc, product).
REQ-017 ACC: if count==VLEN-1, go to OUT and clear count; otherwise increment count and go to LOAD.
REQ-018 count SHALL be $clog2(VLEN)+1 bits wide and never exceed VLEN-1.
REQ-019 OUT: OUT_VALID=1 and RES=acc; on OUT_READY go to LOAD and clear acc to zero.
REQ-020 RES SHALL stay stable while OUT_VALID=1 and OUT_READY=0.
REQ-021 Latency: OUT_VALID SHALL rise 2 cycles after the final handshake edge; throughput is one pair per 3 cycles.
REQ-022 IN_VALID SHALL be ignored in MUL, ACC and OUT; A/B changes outside a handshake SHALL NOT affect the result.
REQ-023 OUT_READY asserted in the same cycle OUT is entered SHALL complete the transfer on the next edge; IN_READY rises that same cycle.
REQ-024 RES SHALL equal acc in every state; it is only meaningful while OUT_VALID=1.

Reset
REQ-025 RST SHALL force, asynchronously: state LOAD, count 0, acc 0, registered operands/product 0, OUT_VALID 0, RES 0, IN_READY 1.
REQ-026 RST asserted mid-vector SHALL discard all partial accumulation; the next vector starts at count 0.

Configuration
REQ-027 Macro FP_DOT_ACC_ABN_FLAG_EN: when defined, SHALL add output ABN (1 bit), set when any accepted A or B has an all-ones exponent.
REQ-028 With the macro, ABN SHALL be sticky until the OUT handshake completes or RST asserts, and SHALL reset to 0.
REQ-029 Without the macro, the port ABN and its logic SHALL NOT exist; all other behaviour is identical.

Verification
REQ-030 VLEN=4, pairs (3F800000,40000000),(40400000,40800000),(3F000000,40000000),(3F800000,3F800000) -> RES=41800000 (16.0), OUT_VALID 2 cycles after 4th handshake.
REQ-031 Pairs (BF800000,40000000),(40400000,40000000),(3F800000,3F800000),(3F800000,3F800000) -> RES=40C00000 (6.0).
REQ-032 OUT_READY held 0 for 5 cycles after OUT_VALID -> RES stable, IN_READY=0, IN_VALID pulses ignored; OUT_READY=1 -> IN_READY=1 next cycle.
REQ-033 RST pulse after 2 of 4 pairs, then test REQ-030 vectors -> RES=41800000 (no residue from aborted vector).
REQ-034 IN_VALID held 1 continuously with changing A/B -> exactly one pair captured per LOAD cycle; 4 captures per result.
REQ-035 With FP_DOT_ACC_ABN_FLAG_EN, first A=7F800000 -> ABN=1 through OUT, ABN=0 after OUT handshake; without macro, bench elaborates without ABN.
